mdio_phy_responder: RTL and testbench

PHY-side Clause 22 MDIO management target that answers the TSE MAC's MDIO master in the HIL simulation. It oversamples MDC/MDIO on the system clock, decodes read and write frames addressed to its PHY address, and serves a 32 x 16-bit register file. The register file holds standard BMCR/BMSR/ID registers plus scratch registers. It lets MAC/driver bring-up run against an emulated PHY instead of silicon.

---
 rtl/mdio_phy_responder.sv | 210 +++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY target: MDC/MDIO oversampled on clk_clk, serves a 32 x 16-bit register file.
// Optional MDIO_PHY_SOFT_RESET_EN: writing BMCR with bit15 set restores all RW registers to defaults.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        link_up,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);
  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_ADDR, S_TA, S_DATA} state_e;

  localparam logic [15:0] BMCR_RST = 16'h1140;
  localparam logic [15:0] BMSR_VAL = 16'h7949;

  state_e      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [8:0]  addr_q, addr_d;
  logic        ours_q, ours_d;
  logic [15:0] sh_q, sh_d;
  logic        oen_q, oen_d;
  logic        out_q, out_d;
  logic        wr_stb_q, wr_stb_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] rf_q [32];
  logic        mdc_q1, mdc_q2, mdio_q1, mdio_q2;
  logic        mdc_rise, din, is_rd, is_wr;
  logic [9:0]  frame_addr;
  logic [15:0] rd_val;

  assign mdc_rise   = mdc_q1 & ~mdc_q2;
  assign din        = mdio_q2;
  assign frame_addr = {addr_q, din};
  assign is_rd      = ours_q & (op_q == 2'b10);
  assign is_wr      = ours_q & (op_q == 2'b01);

  assign mdio_out  = out_q;
  assign mdio_oen  = oen_q;
  assign wr_strobe = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mdc_q1  <= 1'b0;
      mdc_q2  <= 1'b0;
      mdio_q1 <= 1'b1;
      mdio_q2 <= 1'b1;
    end else begin
      mdc_q1  <= mdc;
      mdc_q2  <= mdc_q1;
      mdio_q1 <= mdio_in;
      mdio_q2 <= mdio_q1;
    end
  end

  // BMSR link bits (5 and 2) reflect link_up at the moment the read word is latched.
  always_comb begin
    case (frame_addr[4:0])
      5'd1:    rd_val = BMSR_VAL | {10'b0, link_up, 2'b0, link_up, 2'b0};
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      default: rd_val = rf_q[frame_addr[4:0]];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    ours_d    = ours_q;
    sh_d      = sh_q;
    oen_d     = oen_q;
    out_d     = out_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (din) begin
            if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            if (pre_cnt_q == 6'd32) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          pre_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = din ? S_OP : S_IDLE;
        end
        S_OP: begin
          op_d      = {op_q[0], din};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd1) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
          end
        end
        S_ADDR: begin
          addr_d    = frame_addr[8:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d   = S_TA;
            bit_cnt_d = '0;
            ours_d    = (frame_addr[9:5] == PHY_ADDR) && (op_q == 2'b10 || op_q == 2'b01);
            sh_d      = rd_val;
          end
        end
        S_TA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (is_rd) begin
              oen_d = 1'b0;
              out_d = 1'b0;
            end
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            sh_d      = {sh_q[14:0], din};
            if (is_rd) out_d = sh_q[15];
          end
        end
        S_DATA: begin
          // One shift register serves both directions: MSB drives reads, LSB collects writes.
          sh_d      = {sh_q[14:0], din};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (is_rd) out_d = sh_q[15];
          if (bit_cnt_q == 4'd15) begin
            state_d   = S_IDLE;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
            oen_d     = 1'b1;
            out_d     = 1'b1;
            if (is_wr) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q[4:0];
              wr_data_d = {sh_q[14:0], din};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      bit_cnt_q <= '0;
      ours_q    <= 1'b0;
      oen_q     <= 1'b1;
      out_q     <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      ours_q    <= ours_d;
      oen_q     <= oen_d;
      out_q     <= out_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    op_q   <= op_d;
    addr_q <= addr_d;
    sh_q   <= sh_d;
  end

  // Registers 1..3 are constant; writes to them still strobe but never land.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      rf_q[0] <= BMCR_RST;
    end else if (wr_stb_d && (wr_addr_d == 5'd0 || wr_addr_d > 5'd3)) begin
`ifdef MDIO_PHY_SOFT_RESET_EN
      if (wr_addr_d == 5'd0 && wr_data_d[15]) begin
        for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        rf_q[0] <= BMCR_RST;
      end else begin
        rf_q[wr_addr_d] <= wr_data_d;
      end
`else
      rf_q[wr_addr_d] <= wr_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: acts as the MDIO master at 2.5 MHz MDC on a 50 MHz clk_clk.
module tb_mdio_phy_responder;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int          n_assert = 0;
  int          n_fail = 0;
  int          stb_cnt = 0;
  int          s0;
  logic [4:0]  lst_addr = '0;
  logic [15:0] lst_data = '0;
  logic        samp_oen, samp_out;
  logic [15:0] r_rd;
  logic        r_oenk, r_oenta2, r_outta2, r_oenend, r_all, r_any;
  logic [13:0] hdr7;

  mdio_phy_responder dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .mdc          (mdc),
    .mdio_in      (mdio_in),
    .mdio_out     (mdio_out),
    .mdio_oen     (mdio_oen),
    .link_up      (link_up),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #10 clk_clk = ~clk_clk;

  always @(posedge clk_clk) begin
    if (wr_strobe) begin
      stb_cnt  <= stb_cnt + 1;
      lst_addr <= wr_addr;
      lst_data <= wr_data;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MDC period of 400 ns; line sampled 95 ns after the rising edge.
  task automatic mdc_cycle(input logic b);
    mdio_in = b;
    #200 mdc = 1'b1;
    #95 samp_oen = mdio_oen;
    samp_out = mdio_out;
    #105 mdc = 1'b0;
  endtask

  task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd);
    logic [13:0] hdr;
    logic        wr;
    hdr = {2'b01, op, pa, ra};
    wr = (op == 2'b01);
    r_rd = '0;
    r_any = 1'b0;
    r_all = 1'b1;
    for (int i = 0; i < npre; i++) begin
      mdc_cycle(1'b1);
      r_any |= ~samp_oen;
    end
    for (int i = 13; i >= 0; i--) begin
      mdc_cycle(hdr[i]);
      r_any |= ~samp_oen;
    end
    r_oenk = samp_oen;
    mdc_cycle(1'b1);
    r_oenta2 = samp_oen;
    r_outta2 = samp_out;
    r_any |= ~samp_oen;
    mdc_cycle(wr ? 1'b0 : 1'b1);
    r_rd = {r_rd[14:0], samp_out};
    r_all &= ~samp_oen;
    r_any |= ~samp_oen;
    for (int i = 15; i >= 0; i--) begin
      mdc_cycle(wr ? wd[i] : 1'b1);
      r_any |= ~samp_oen;
      if (i > 0) begin
        r_rd = {r_rd[14:0], samp_out};
        r_all &= ~samp_oen;
      end
    end
    r_oenend = samp_oen;
  endtask

  task automatic rd_frame(input int npre, input logic [4:0] pa, input logic [4:0] ra);
    frame(npre, 2'b10, pa, ra, 16'h0000);
  endtask

  task automatic wr_frame(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    frame(32, 2'b01, pa, ra, wd);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    mdc = 1'b0;
    mdio_in = 1'b1;
    link_up = 1'b0;
    samp_oen = 1'b1;
    samp_out = 1'b1;
    repeat (3) @(negedge clk_clk);
    chk("rst_oen", {15'b0, mdio_oen}, 16'h1);
    chk("rst_out", {15'b0, mdio_out}, 16'h1);
    chk("rst_stb", {15'b0, wr_strobe}, 16'h0);
    chk("rst_waddr", {11'b0, wr_addr}, 16'h0);
    chk("rst_wdata", wr_data, 16'h0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    rd_frame(32, 5'd1, 5'd2);
    chk("id1_ta1_released", {15'b0, r_oenk}, 16'h1);
    chk("id1_ta2_driven", {15'b0, r_oenta2}, 16'h0);
    chk("id1_ta2_zero", {15'b0, r_outta2}, 16'h0);
    chk("id1_data_driven", {15'b0, r_all}, 16'h1);
    chk("id1_data", r_rd, 16'h0141);
    chk("id1_release_end", {15'b0, r_oenend}, 16'h1);

    s0 = stb_cnt;
    wr_frame(5'd1, 5'd17, 16'hA5A5);
    chk("wr17_pulses", 16'(stb_cnt - s0), 16'd1);
    chk("wr17_addr", {11'b0, lst_addr}, 16'd17);
    chk("wr17_data", lst_data, 16'hA5A5);
    rd_frame(32, 5'd1, 5'd17);
    chk("rd17", r_rd, 16'hA5A5);

    rd_frame(32, 5'd2, 5'd0);
    chk("other_phy_rd_nodrive", {15'b0, r_any}, 16'h0);
    s0 = stb_cnt;
    wr_frame(5'd2, 5'd5, 16'h1111);
    chk("other_phy_wr_nostb", 16'(stb_cnt - s0), 16'd0);
    rd_frame(32, 5'd1, 5'd5);
    chk("rd5_untouched", r_rd, 16'h0000);

    link_up = 1'b1;
    rd_frame(32, 5'd1, 5'd1);
    chk("bmsr_link1", r_rd, 16'h796D);
    link_up = 1'b0;
    rd_frame(32, 5'd1, 5'd1);
    chk("bmsr_link0", r_rd, 16'h7949);
    s0 = stb_cnt;
    wr_frame(5'd1, 5'd1, 16'hFFFF);
    chk("bmsr_wr_pulses", 16'(stb_cnt - s0), 16'd1);
    rd_frame(32, 5'd1, 5'd1);
    chk("bmsr_ro", r_rd, 16'h7949);
    rd_frame(32, 5'd1, 5'd3);
    chk("id2", r_rd, 16'h0CC2);

    rd_frame(31, 5'd1, 5'd2);
    chk("short_pre_ignored", {15'b0, r_any}, 16'h0);
    rd_frame(32, 5'd1, 5'd2);
    chk("after_short_pre", r_rd, 16'h0141);

    wr_frame(5'd1, 5'd4, 16'h1234);
    wr_frame(5'd1, 5'd0, 16'h8000);
    rd_frame(32, 5'd1, 5'd4);
`ifdef MDIO_PHY_SOFT_RESET_EN
    chk("softrst_reg4", r_rd, 16'h0000);
    rd_frame(32, 5'd1, 5'd0);
    chk("softrst_bmcr", r_rd, 16'h1140);
`else
    chk("nosoftrst_reg4", r_rd, 16'h1234);
    rd_frame(32, 5'd1, 5'd0);
    chk("nosoftrst_bmcr", r_rd, 16'h8000);
`endif

    hdr7 = {2'b01, 2'b10, 5'd1, 5'd2};
    for (int i = 0; i < 32; i++) mdc_cycle(1'b1);
    for (int i = 13; i >= 0; i--) mdc_cycle(hdr7[i]);
    mdc_cycle(1'b1);
    mdc_cycle(1'b1);
    for (int i = 0; i < 4; i++) mdc_cycle(1'b1);
    chk("midread_driving", {15'b0, samp_oen}, 16'h0);
    #7 reset_reset_n = 1'b0;
    #1 chk("midread_rst_oen", {15'b0, mdio_oen}, 16'h1);
    chk("midread_rst_out", {15'b0, mdio_out}, 16'h1);
    #12;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    rd_frame(32, 5'd1, 5'd17);
    chk("post_rst_reg17", r_rd, 16'h0000);
    rd_frame(32, 5'd1, 5'd0);
    chk("post_rst_bmcr", r_rd, 16'h1140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
